quant_uv_levels: RTL and testbench
==================================

Name: quant_uv_levels

Overview:
- Chroma (U/V) quantizer and level writer for the per-macroblock RD path.
- Takes BLOCK_SIZE 4x4 blocks of signed transform coefficients and produces the packed, zigzag-ordered quantized level bus read by the UV cost unit.
- Also produces dequantized coefficients for reconstruction and a per-block non-zero map.
- Processes one 4x4 block per cycle through a 2-stage pipeline, then pulses done.

Parameters:
- BIT_WIDTH, 16, width of each signed coefficient/level lane
- BLOCK_SIZE, 8, number of 4x4 blocks per run
- QFIX, 17, fixed-point shift for the reciprocal quantizer
- MAX_LEVEL, 2047, magnitude clamp for levels

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; accepted only when busy=0
- coeffs  in  BIT_WIDTH*16*BLOCK_SIZE  block b, raster coefficient k at [BIT_WIDTH*(16b+k) +: BIT_WIDTH], signed; held stable while busy
- q_dc / q_ac  in  16  dequant step (k=0 / k!=0)
- iq_dc / iq_ac  in  17  reciprocal, approx 2^QFIX/q
- bias_dc / bias_ac  in  32  rounding bias
- zthresh_dc / zthresh_ac  in  16  zero threshold on |coeff|
- levels  out  BIT_WIDTH*16*BLOCK_SIZE  block b, zigzag position n at [BIT_WIDTH*(16b+n) +: BIT_WIDTH], signed
- dq_coeffs  out  BIT_WIDTH*16*BLOCK_SIZE  dequantized coefficients, raster order, signed
- nz  out  BLOCK_SIZE  bit b=1 if any level of block b is non-zero
- busy  out  1  run in progress
- done  out  1  one-cycle pulse; all outputs of the run valid

Behaviour:
- Reset (rst_n=0, async) clears:
  - levels, dq_coeffs, nz, busy, done = 0
  - FSM to IDLE; block counter and pipeline valids = 0
  - Reset mid-run aborts the run with no done.
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- FSM: IDLE -> RUN on start & !busy; RUN -> DRAIN after block BLOCK_SIZE-1 is issued; DRAIN -> IDLE when stage 2 retires the last block.
- busy: 1 from the edge after start is accepted until done rises; start is ignored while busy=1.
- Zigzag: level position n takes raster coefficient Z[n], Z = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
- Per coefficient c at raster index k (DC parameters when k=0, AC otherwise):
  - a = |c| (16-bit unsigned; -32768 gives 32768), s = sign(c).
  - If a <= zthresh: L = 0.
  - Else L = min((a*iq + bias) >> QFIX, MAX_LEVEL); product and sum are 34-bit unsigned, no overflow.
  - level = s ? -L : L.
  - dq = level*q, saturated to signed BIT_WIDTH range [-32768, 32767].
- Pipeline:
  - Stage 1 registers a, s, and a*iq+bias for all 16 lanes of block idx.
  - Stage 2 applies shift, clamp, sign and dequant, and writes block idx's slice of levels/dq_coeffs plus nz[idx].
- Timing (start sampled at edge E0):
  - Block b enters stage 1 at edge E(b+1).
  - Block b is written at edge E(b+2).
  - done=1 for exactly the cycle after edge E(BLOCK_SIZE+1), i.e. edge E9 for defaults (latency 9).
- Outputs hold their values after done until overwritten block-by-block by the next run. They are not cleared on start.
- Downstream must not issue a new start while it is still reading levels.
- start is accepted in the same cycle done=1 (busy already 0); done still pulses once only.
- Parameter inputs (q, iq, bias, zthresh) are sampled live and must be stable while busy.

Test Plan:
- All coeffs=0, zthresh=0, start at E0 -> levels=0, dq=0, nz=0; busy high E1..E8; done high only after E9.
- Block0 k=0 c=100, q_dc=10, iq_dc=13107, bias_dc=65536, zthresh_dc=0 -> level pos0=10, dq raster0=100, nz=8'h01; c=-100 -> level -10, dq -100.
- Block3 raster k=5 c=32767, iq_ac=131071, bias_ac=0, q_ac=157 -> levels block3 pos4=2047, dq=32767 (saturated), nz[3]=1.
- Block5 k=2 c=20, zthresh_ac=20, bias_ac=2^31, iq_ac=131071 -> level 0, nz[5]=0; with c=21 -> non-zero level, nz[5]=1.
- Second start pulsed at E3 during a run -> ignored; exactly one done at E9. start asserted in the done cycle -> new run starts, second done 9 edges later.
- rst_n low at E4 -> all outputs 0 asynchronously; no done; a new start after release runs normally.

Source files
------------

// File: rtl/quant_uv_levels.sv
// ---------------------------------------------------------------------------
// quant_uv_levels
//   Chroma (U/V) quantizer and level writer for the per-macroblock RD path.
//   A run walks BLOCK_SIZE 4x4 blocks of signed transform coefficients, one
//   block per cycle, through a two-stage pipeline:
//     stage 1 : |c|, sign(c) and |c|*iq + bias for all 16 lanes
//     stage 2 : shift, clamp, sign, dequant; writes the block's output slice
//   and pulses done once the last block has been written.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle run request, ignored while busy
//   coeffs                  block b raster k at [BIT_WIDTH*(16b+k) +: BIT_WIDTH]
//   q_dc / q_ac             dequant step (k==0 / k!=0)
//   iq_dc / iq_ac           reciprocal step, ~2^QFIX/q
//   bias_dc / bias_ac       rounding bias added before the shift
//   zthresh_dc / _ac        |coeff| at or below this quantizes to zero
//   levels                  block b zigzag pos n at [BIT_WIDTH*(16b+n) +: BIT_WIDTH]
//   dq_coeffs               dequantized coefficients, raster order
//   nz                      bit b set when block b has any non-zero level
//   busy                    run in progress
//   done                    one-cycle pulse, all outputs of the run valid
// ---------------------------------------------------------------------------
module quant_uv_levels #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int QFIX       = 17,
    parameter int MAX_LEVEL  = 2047
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] coeffs,
    input  logic [15:0]                       q_dc,
    input  logic [15:0]                       q_ac,
    input  logic [16:0]                       iq_dc,
    input  logic [16:0]                       iq_ac,
    input  logic [31:0]                       bias_dc,
    input  logic [31:0]                       bias_ac,
    input  logic [15:0]                       zthresh_dc,
    input  logic [15:0]                       zthresh_ac,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] levels,
    output logic [BIT_WIDTH*16*BLOCK_SIZE-1:0] dq_coeffs,
    output logic [BLOCK_SIZE-1:0]             nz,
    output logic                              busy,
    output logic                              done
);

    localparam int IDXW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BLOCK_SIZE - 1);

    // |c| * iq + bias fits in 34 bits without overflow.
    localparam int SUMW = 34;
    // Clamped level magnitude times a 16-bit step.
    localparam int DQW  = BIT_WIDTH + 16;

    localparam logic [SUMW-1:0]      LEVEL_MAX  = SUMW'(MAX_LEVEL);
    localparam logic [DQW-1:0]       DQ_POS_LIM = DQW'((64'd1 << (BIT_WIDTH - 1)) - 64'd1);
    localparam logic [DQW-1:0]       DQ_NEG_LIM = DQW'(64'd1 << (BIT_WIDTH - 1));
    localparam logic [BIT_WIDTH-1:0] SAT_POS    = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] SAT_NEG    = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Zigzag position n -> raster index.
    function automatic int unsigned zz_raster(input int unsigned n);
        case (n)
            0:       zz_raster = 0;
            1:       zz_raster = 1;
            2:       zz_raster = 4;
            3:       zz_raster = 8;
            4:       zz_raster = 5;
            5:       zz_raster = 2;
            6:       zz_raster = 3;
            7:       zz_raster = 6;
            8:       zz_raster = 9;
            9:       zz_raster = 12;
            10:      zz_raster = 13;
            11:      zz_raster = 10;
            12:      zz_raster = 7;
            13:      zz_raster = 11;
            14:      zz_raster = 14;
            default: zz_raster = 15;
        endcase
    endfunction

    // Flat buses viewed as [block][lane][bit]; layout is identical.
    logic [BLOCK_SIZE-1:0][15:0][BIT_WIDTH-1:0] coeff_blk;
    logic [BLOCK_SIZE-1:0][15:0][BIT_WIDTH-1:0] levels_r;
    logic [BLOCK_SIZE-1:0][15:0][BIT_WIDTH-1:0] dq_r;
    logic [BLOCK_SIZE-1:0]                      nz_r;

    assign coeff_blk = coeffs;
    assign levels    = levels_r;
    assign dq_coeffs = dq_r;
    assign nz        = nz_r;

    logic [1:0]      state;
    logic [IDXW-1:0] blk_cnt;

    // Stage 1 next-state (combinational, from block blk_cnt).
    logic [15:0][BIT_WIDTH-1:0] s1_a_d;
    logic [15:0]                s1_sgn_d;
    logic [15:0][SUMW-1:0]      s1_sum_d;

    // Stage 1 registers.
    logic                       s1_valid;
    logic [IDXW-1:0]            s1_idx;
    logic [15:0][BIT_WIDTH-1:0] s1_a;
    logic [15:0]                s1_sgn;
    logic [15:0][SUMW-1:0]      s1_sum;

    // Stage 2 combinational results.
    logic [15:0][SUMW-1:0]      s2_shift;
    logic [15:0][BIT_WIDTH-1:0] s2_mag;
    logic [15:0][BIT_WIDTH-1:0] s2_lev;
    logic [15:0][DQW-1:0]       s2_dqmag;
    logic [15:0][BIT_WIDTH-1:0] s2_dq;
    logic [15:0][BIT_WIDTH-1:0] s2_zz;
    logic                       s2_nz;

    assign busy = (state != S_IDLE);

    // ---------------------------------------------------------------- stage 1
    always_comb begin
        s1_a_d   = '0;
        s1_sgn_d = '0;
        s1_sum_d = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            s1_sgn_d[k] = coeff_blk[blk_cnt][k][BIT_WIDTH-1];
            // Negating the most negative value wraps to 2^(BIT_WIDTH-1),
            // which is the correct magnitude when read as unsigned.
            s1_a_d[k]   = s1_sgn_d[k] ? (BIT_WIDTH'(0) - coeff_blk[blk_cnt][k])
                                      : coeff_blk[blk_cnt][k];
            s1_sum_d[k] = SUMW'(s1_a_d[k]) * SUMW'((k == 0) ? iq_dc : iq_ac)
                        + SUMW'((k == 0) ? bias_dc : bias_ac);
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        s2_shift = '0;
        s2_mag   = '0;
        s2_lev   = '0;
        s2_dqmag = '0;
        s2_dq    = '0;
        s2_zz    = '0;
        s2_nz    = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            s2_shift[k] = s1_sum[k] >> QFIX;
            if (32'(s1_a[k]) <= 32'((k == 0) ? zthresh_dc : zthresh_ac)) begin
                s2_mag[k] = '0;
            end else if (s2_shift[k] > LEVEL_MAX) begin
                s2_mag[k] = BIT_WIDTH'(MAX_LEVEL);
            end else begin
                s2_mag[k] = s2_shift[k][BIT_WIDTH-1:0];
            end
            s2_lev[k] = s1_sgn[k] ? (BIT_WIDTH'(0) - s2_mag[k]) : s2_mag[k];

            // Dequant on the magnitude, then saturate per sign.
            s2_dqmag[k] = DQW'(s2_mag[k]) * DQW'((k == 0) ? q_dc : q_ac);
            if (s1_sgn[k]) begin
                s2_dq[k] = (s2_dqmag[k] > DQ_NEG_LIM) ? SAT_NEG
                         : (BIT_WIDTH'(0) - s2_dqmag[k][BIT_WIDTH-1:0]);
            end else begin
                s2_dq[k] = (s2_dqmag[k] > DQ_POS_LIM) ? SAT_POS
                         : s2_dqmag[k][BIT_WIDTH-1:0];
            end
            s2_nz = s2_nz | (|s2_mag[k]);
        end
        for (int unsigned n = 0; n < 16; n++) begin
            s2_zz[n] = s2_lev[zz_raster(n)];
        end
    end

    // ------------------------------------------------------- control + state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            blk_cnt  <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_a     <= '0;
            s1_sgn   <= '0;
            s1_sum   <= '0;
            done     <= 1'b0;
            levels_r <= '0;
            dq_r     <= '0;
            nz_r     <= '0;
        end else begin
            done     <= 1'b0;
            s1_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        blk_cnt <= '0;
                    end
                end
                S_RUN: begin
                    s1_valid <= 1'b1;
                    s1_idx   <= blk_cnt;
                    s1_a     <= s1_a_d;
                    s1_sgn   <= s1_sgn_d;
                    s1_sum   <= s1_sum_d;
                    if (blk_cnt == LAST_IDX) begin
                        state <= S_DRAIN;
                    end else begin
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (s1_valid && (s1_idx == LAST_IDX)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (s1_valid) begin
                levels_r[s1_idx] <= s2_zz;
                dq_r[s1_idx]     <= s2_dq;
                nz_r[s1_idx]     <= s2_nz;
            end
        end
    end

endmodule

// File: tb/tb_quant_uv_levels.sv
module tb_quant_uv_levels;

    localparam int BW  = 16;
    localparam int BS  = 8;
    localparam int BUS = BW * 16 * BS;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [BUS-1:0] coeffs;
    logic [15:0]    q_dc, q_ac;
    logic [16:0]    iq_dc, iq_ac;
    logic [31:0]    bias_dc, bias_ac;
    logic [15:0]    zthresh_dc, zthresh_ac;
    logic [BUS-1:0] levels;
    logic [BUS-1:0] dq_coeffs;
    logic [BS-1:0]  nz;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    quant_uv_levels #(
        .BIT_WIDTH (BW),
        .BLOCK_SIZE(BS),
        .QFIX      (17),
        .MAX_LEVEL (2047)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .coeffs    (coeffs),
        .q_dc      (q_dc),
        .q_ac      (q_ac),
        .iq_dc     (iq_dc),
        .iq_ac     (iq_ac),
        .bias_dc   (bias_dc),
        .bias_ac   (bias_ac),
        .zthresh_dc(zthresh_dc),
        .zthresh_ac(zthresh_ac),
        .levels    (levels),
        .dq_coeffs (dq_coeffs),
        .nz        (nz),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lev(input int b, input int n);
        return levels[BW*(16*b+n) +: BW];
    endfunction

    function automatic logic [15:0] dqv(input int b, input int k);
        return dq_coeffs[BW*(16*b+k) +: BW];
    endfunction

    task automatic set_c(input int b, input int k, input logic [15:0] v);
        coeffs[BW*(16*b+k) +: BW] = v;
    endtask

    task automatic set_params(input logic [15:0] qd, input logic [16:0] iqd,
                              input logic [31:0] bd, input logic [15:0] zd,
                              input logic [15:0] qa, input logic [16:0] iqa,
                              input logic [31:0] ba, input logic [15:0] za);
        q_dc = qd; iq_dc = iqd; bias_dc = bd; zthresh_dc = zd;
        q_ac = qa; iq_ac = iqa; bias_ac = ba; zthresh_ac = za;
    endtask

    // Pulses start (sampled at E0) and returns the edge index of done, -1 on timeout.
    task automatic do_run(output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (levels !== '0) begin errors++; $display("FAIL reset_levels: got %h expected 0", levels[255:0]); end
        checks++; if (dq_coeffs !== '0) begin errors++; $display("FAIL reset_dq: got %h expected 0", dq_coeffs[255:0]); end
        checks++; if (nz !== 8'h00) begin errors++; $display("FAIL reset_nz: got %h expected 00", nz); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got busy %b done %b expected 0 0", busy, done); end
    endtask

    task automatic test_zero_run;
        coeffs = '0;
        set_params(16'd1, 17'd0, 32'd0, 16'd0, 16'd1, 17'd131071, 32'h8000_0000, 16'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_e0: got %b expected 1", busy); end
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            if (e < 9) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_busy_e%0d: got busy %b done %b expected 1 0", e, busy, done); end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zero_done_e9: got busy %b done %b expected 0 1", busy, done); end
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_single: got %b expected 0", done); end
        checks++; if (levels !== '0) begin errors++; $display("FAIL zero_levels: got %h expected 0", levels[255:0]); end
        checks++; if (dq_coeffs !== '0) begin errors++; $display("FAIL zero_dq: got %h expected 0", dq_coeffs[255:0]); end
        checks++; if (nz !== 8'h00) begin errors++; $display("FAIL zero_nz: got %h expected 00", nz); end
    endtask

    task automatic test_dc;
        int lat;
        coeffs = '0;
        set_params(16'd10, 17'd13107, 32'd65536, 16'd0, 16'd1, 17'd0, 32'd0, 16'd0);
        set_c(0, 0, 16'd100);
        set_c(7, 0, 16'd100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                checks++; if (lev(0, 0) !== 16'd0) begin errors++; $display("FAIL dc_blk0_early: got %h expected 0000", lev(0, 0)); end
            end
            if (e == 2) begin
                checks++; if (lev(0, 0) !== 16'd10) begin errors++; $display("FAIL dc_blk0_e2: got %h expected 000a", lev(0, 0)); end
            end
            if (e == 8) begin
                checks++; if (lev(7, 0) !== 16'd0) begin errors++; $display("FAIL dc_blk7_early: got %h expected 0000", lev(7, 0)); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dc_done_e9: got %b expected 1", done); end
        checks++; if (lev(7, 0) !== 16'd10) begin errors++; $display("FAIL dc_blk7_e9: got %h expected 000a", lev(7, 0)); end
        checks++; if (dqv(0, 0) !== 16'd100) begin errors++; $display("FAIL dc_dq_pos: got %h expected 0064", dqv(0, 0)); end
        checks++; if (nz !== 8'h81) begin errors++; $display("FAIL dc_nz_pos: got %h expected 81", nz); end

        @(posedge clk); #1;
        coeffs = '0;
        set_c(0, 0, 16'hFF9C);
        do_run(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL dc_neg_latency: got %0d expected 9", lat); end
        checks++; if (lev(0, 0) !== 16'hFFF6) begin errors++; $display("FAIL dc_level_neg: got %h expected fff6", lev(0, 0)); end
        checks++; if (dqv(0, 0) !== 16'hFF9C) begin errors++; $display("FAIL dc_dq_neg: got %h expected ff9c", dqv(0, 0)); end
        checks++; if (nz !== 8'h01) begin errors++; $display("FAIL dc_nz_neg: got %h expected 01", nz); end
        checks++; if (lev(7, 0) !== 16'd0) begin errors++; $display("FAIL dc_blk7_rewrite: got %h expected 0000", lev(7, 0)); end
        @(posedge clk); #1;
    endtask

    task automatic test_clamp;
        int lat;
        coeffs = '0;
        set_params(16'd1, 17'd0, 32'd0, 16'd0, 16'd157, 17'd131071, 32'd0, 16'd0);
        set_c(3, 5, 16'h7FFF);
        set_c(6, 15, 16'h8000);
        do_run(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL clamp_latency: got %0d expected 9", lat); end
        checks++; if (lev(3, 4) !== 16'h07FF) begin errors++; $display("FAIL clamp_level_pos: got %h expected 07ff", lev(3, 4)); end
        checks++; if (dqv(3, 5) !== 16'h7FFF) begin errors++; $display("FAIL clamp_dq_satpos: got %h expected 7fff", dqv(3, 5)); end
        checks++; if (lev(6, 15) !== 16'hF801) begin errors++; $display("FAIL clamp_level_neg: got %h expected f801", lev(6, 15)); end
        checks++; if (dqv(6, 15) !== 16'h8000) begin errors++; $display("FAIL clamp_dq_satneg: got %h expected 8000", dqv(6, 15)); end
        checks++; if (nz !== 8'h48) begin errors++; $display("FAIL clamp_nz: got %h expected 48", nz); end
        @(posedge clk); #1;
    endtask

    task automatic test_zthresh;
        int lat;
        coeffs = '0;
        set_params(16'd1, 17'd0, 32'd0, 16'd0, 16'd1, 17'd131071, 32'h8000_0000, 16'd20);
        set_c(5, 2, 16'd20);
        do_run(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL zth_latency: got %0d expected 9", lat); end
        checks++; if (lev(5, 5) !== 16'd0) begin errors++; $display("FAIL zth_at_level: got %h expected 0000", lev(5, 5)); end
        checks++; if (nz !== 8'h00) begin errors++; $display("FAIL zth_at_nz: got %h expected 00", nz); end
        @(posedge clk); #1;
        set_c(5, 2, 16'd21);
        do_run(lat);
        checks++; if (lev(5, 5) !== 16'h07FF) begin errors++; $display("FAIL zth_above_level: got %h expected 07ff", lev(5, 5)); end
        checks++; if (dqv(5, 2) !== 16'h07FF) begin errors++; $display("FAIL zth_above_dq: got %h expected 07ff", dqv(5, 2)); end
        checks++; if (nz !== 8'h20) begin errors++; $display("FAIL zth_above_nz: got %h expected 20", nz); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int ndone = 0;
        int first = -1;
        int second = -1;
        coeffs = '0;
        set_params(16'd10, 17'd13107, 32'd65536, 16'd0, 16'd1, 17'd0, 32'd0, 16'd0);
        set_c(0, 0, 16'd100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = e;
                else if (second < 0) second = e;
            end
            if (e == 11) begin
                checks++; if (lev(0, 0) !== 16'd10 || busy !== 1'b1) begin errors++; $display("FAIL b2b_hold_on_start: got level %h busy %b expected 000a 1", lev(0, 0), busy); end
            end
            start = (e == 2) || (done === 1'b1 && ndone == 1);
        end
        start = 1'b0;
        checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
        checks++; if (first !== 9) begin errors++; $display("FAIL b2b_first_done: got %0d expected 9", first); end
        checks++; if (second !== 19) begin errors++; $display("FAIL b2b_second_done: got %0d expected 19", second); end
        checks++; if (nz !== 8'h01) begin errors++; $display("FAIL b2b_nz: got %h expected 01", nz); end
    endtask

    task automatic test_reset_midrun;
        int lat;
        int stray = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (lev(0, 0) !== 16'd10) begin errors++; $display("FAIL rst_pre_level: got %h expected 000a", lev(0, 0)); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (levels !== '0 || dq_coeffs !== '0) begin errors++; $display("FAIL rst_async_data: got level0 %h dq0 %h expected 0000 0000", lev(0, 0), dqv(0, 0)); end
        checks++; if (nz !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_ctrl: got nz %h busy %b done %b expected 00 0 0", nz, busy, done); end
        repeat (2) begin @(posedge clk); #1; if (done === 1'b1) stray++; end
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) stray++; end
        checks++; if (stray !== 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles expected 0", stray); end
        do_run(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL rst_rerun_latency: got %0d expected 9", lat); end
        checks++; if (lev(0, 0) !== 16'd10 || nz !== 8'h01) begin errors++; $display("FAIL rst_rerun_result: got level %h nz %h expected 000a 01", lev(0, 0), nz); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        coeffs = '0;
        set_params(16'd0, 17'd0, 32'd0, 16'd0, 16'd0, 17'd0, 32'd0, 16'd0);
        test_reset;
        test_zero_run;
        test_dc;
        test_clamp;
        test_zthresh;
        test_back_to_back;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
